vram_dump: RTL and testbench



---
 rtl/vram_dump_if.sv | 45 ++++
 rtl/vram_dump.sv | 223 ++++++++++++++++++++++
 tb/tb_vram_dump.sv | 359 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vram_dump_if.sv
// -----------------------------------------------------------------------------
// vram_dump_if
//
// Bundles the two buses of the VRAM dumper:
//   - the outgoing character stream (valid/ready handshake)
//       data   : character being offered (o_char)
//       valid  : data is offered (o_valid)
//       ready  : consumer accepts (i_ready)
//   - the VRAM read port
//       vram_addr : {row[4:0], col[5:0]} (o_vram_addr)
//       vram_ce   : read strobe (o_vram_ce)
//       vram_w    : write enable, always 0 (o_vram_w)
//       vram_dout : read data, valid the cycle after vram_ce (i_vram_dout)
//
// master: the dumper side. slave: consumer / VRAM side.
// -----------------------------------------------------------------------------
interface vram_dump_if;
  logic [7:0]  data;
  logic        valid;
  logic        ready;
  logic [10:0] vram_addr;
  logic        vram_ce;
  logic        vram_w;
  logic [7:0]  vram_dout;

  modport master (
    output data,
    output valid,
    input  ready,
    output vram_addr,
    output vram_ce,
    output vram_w,
    input  vram_dout
  );

  modport slave (
    input  data,
    input  valid,
    output ready,
    input  vram_addr,
    input  vram_ce,
    input  vram_w,
    output vram_dout
  );
endinterface

// File: rtl/vram_dump.sv
// -----------------------------------------------------------------------------
// vram_dump
//
// Reads the text VRAM back out and emits the screen as a character stream:
// optional form feed, then for every row its characters followed by CR, and
// LF between rows (no LF after the last row so the receiver does not scroll).
// With TRIM set, trailing spaces of each row are found by scanning the row
// right-to-left before any character of that row is sent.
//
// Parameters:
//   LAST_COL : last column index (columns 0..LAST_COL)
//   LAST_ROW : last row index (rows 0..LAST_ROW)
//   EMIT_FF  : 1 = send 8'h0C before the first row
//   TRIM     : 1 = drop trailing spaces of each row
//
// Ports:
//   i_clk     : clock
//   i_rst     : asynchronous active-high reset
//   i_start   : 1-cycle pulse in idle starts a dump; ignored while running
//   o_running : high while a dump is in progress (VRAM port owned)
//   bus       : master side of vram_dump_if (char stream + VRAM read port)
// -----------------------------------------------------------------------------
module vram_dump #(
  parameter int LAST_COL = 59,
  parameter int LAST_ROW = 16,
  parameter bit EMIT_FF  = 1'b1,
  parameter bit TRIM     = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  output logic        o_running,
  vram_dump_if.master bus
);

  localparam logic [5:0] COL_MAX = 6'(LAST_COL);
  localparam logic [4:0] ROW_MAX = 5'(LAST_ROW);

  localparam logic [7:0] CH_FF = 8'h0C;
  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_SP = 8'h20;
  localparam logic [7:0] CH_DEL = 8'h7F;

  typedef enum logic [3:0] {
    S_IDLE,
    S_SCAN_RD,
    S_SCAN_CHK,
    S_RD,
    S_LOAD,
    S_SEND,
    S_CR,
    S_LF,
    S_FF
  } state_t;

  // Every row starts either with the right-to-left trailing-space scan or,
  // without trimming, directly with the first character read.
  localparam state_t     ROW_ST  = TRIM ? S_SCAN_RD : S_RD;
  localparam logic [5:0] ROW_COL = TRIM ? COL_MAX : 6'd0;

  state_t      state;
  logic [4:0]  row;
  logic [5:0]  col;
  logic [5:0]  last_col;
  logic [7:0]  char_q;
  logic        valid_q;
  logic        ce_q;
  logic [10:0] addr_q;
  logic        running_q;
  logic        hs;

  // Control codes and DEL stored in VRAM (garbage) must never reach the
  // downstream terminal as control characters.
  function automatic logic [7:0] sanitize(input logic [7:0] d);
    if ((d < CH_SP) || (d == CH_DEL)) begin
      return CH_SP;
    end
    return d;
  endfunction

  assign hs = valid_q & bus.ready;

  assign bus.data      = char_q;
  assign bus.valid     = valid_q;
  assign bus.vram_addr = addr_q;
  assign bus.vram_ce   = ce_q;
  assign bus.vram_w    = 1'b0;
  assign o_running     = running_q;

  // All outputs are registered: the read strobe and address are set up on
  // the transition into SCAN_RD / RD so they are high exactly in those
  // states, and valid/char are set on entry to LOAD->SEND, CR, LF and FF.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state     <= S_IDLE;
      row       <= 5'd0;
      col       <= 6'd0;
      last_col  <= 6'd0;
      char_q    <= 8'h00;
      valid_q   <= 1'b0;
      ce_q      <= 1'b0;
      addr_q    <= 11'd0;
      running_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (i_start) begin
            running_q <= 1'b1;
            row       <= 5'd0;
            if (EMIT_FF) begin
              state   <= S_FF;
              valid_q <= 1'b1;
              char_q  <= CH_FF;
            end else begin
              state    <= ROW_ST;
              col      <= ROW_COL;
              last_col <= COL_MAX;
              ce_q     <= 1'b1;
              addr_q   <= {5'd0, ROW_COL};
            end
          end
        end

        S_FF: begin
          if (hs) begin
            valid_q  <= 1'b0;
            state    <= ROW_ST;
            col      <= ROW_COL;
            last_col <= COL_MAX;
            ce_q     <= 1'b1;
            addr_q   <= {5'd0, ROW_COL};
          end
        end

        S_SCAN_RD: begin
          ce_q  <= 1'b0;
          state <= S_SCAN_CHK;
        end

        // The raw VRAM byte decides trimming: only a real space is trailing
        // blank, a control code still counts as content (sent as a space).
        S_SCAN_CHK: begin
          if (bus.vram_dout != CH_SP) begin
            last_col <= col;
            col      <= 6'd0;
            state    <= S_RD;
            ce_q     <= 1'b1;
            addr_q   <= {row, 6'd0};
          end else if (col == 6'd0) begin
            state   <= S_CR;
            valid_q <= 1'b1;
            char_q  <= CH_CR;
          end else begin
            col    <= col - 6'd1;
            state  <= S_SCAN_RD;
            ce_q   <= 1'b1;
            addr_q <= {row, col - 6'd1};
          end
        end

        S_RD: begin
          ce_q  <= 1'b0;
          state <= S_LOAD;
        end

        S_LOAD: begin
          char_q  <= sanitize(bus.vram_dout);
          valid_q <= 1'b1;
          state   <= S_SEND;
        end

        S_SEND: begin
          if (hs) begin
            if (col == last_col) begin
              char_q <= CH_CR;
              state  <= S_CR;
            end else begin
              valid_q <= 1'b0;
              col     <= col + 6'd1;
              state   <= S_RD;
              ce_q    <= 1'b1;
              addr_q  <= {row, col + 6'd1};
            end
          end
        end

        S_CR: begin
          if (hs) begin
            if (row != ROW_MAX) begin
              char_q <= CH_LF;
              state  <= S_LF;
            end else begin
              valid_q   <= 1'b0;
              running_q <= 1'b0;
              state     <= S_IDLE;
            end
          end
        end

        S_LF: begin
          if (hs) begin
            valid_q  <= 1'b0;
            row      <= row + 5'd1;
            col      <= ROW_COL;
            last_col <= COL_MAX;
            state    <= ROW_ST;
            ce_q     <= 1'b1;
            addr_q   <= {row + 5'd1, ROW_COL};
          end
        end

        default: begin
          valid_q   <= 1'b0;
          ce_q      <= 1'b0;
          running_q <= 1'b0;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vram_dump.sv
`timescale 1ns/1ps
module tb_vram_dump;
  localparam int LC = 59;
  localparam int LR = 16;

  typedef logic [7:0] bq_t [$];

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic start_a, start_b;
  logic run_a, run_b;

  vram_dump_if bus_a ();
  vram_dump_if bus_b ();

  // a: form feed + trimming; b: no form feed, full rows
  vram_dump #(.LAST_COL(LC), .LAST_ROW(LR), .EMIT_FF(1'b1), .TRIM(1'b1)) dut_a (
    .i_clk(clk), .i_rst(rst), .i_start(start_a), .o_running(run_a), .bus(bus_a)
  );
  vram_dump #(.LAST_COL(LC), .LAST_ROW(LR), .EMIT_FF(1'b0), .TRIM(1'b0)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_start(start_b), .o_running(run_b), .bus(bus_b)
  );

  // shared screen memory, one synchronous read port per DUT
  logic [7:0] mem [0:2047];
  always @(posedge clk) begin
    if (bus_a.vram_ce) bus_a.vram_dout <= mem[bus_a.vram_addr];
    if (bus_b.vram_ce) bus_b.vram_dout <= mem[bus_b.vram_addr];
  end

  // ready: mode 0 = always, 1 = random, 2 = manual (a only)
  int   mode_a, mode_b;
  logic rnd_rdy_a, rnd_rdy_b, man_rdy_a;
  assign bus_a.ready = (mode_a == 2) ? man_rdy_a : rnd_rdy_a;
  assign bus_b.ready = rnd_rdy_b;
  initial begin
    rnd_rdy_a = 1'b1;
    rnd_rdy_b = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      rnd_rdy_a = (mode_a == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
      rnd_rdy_b = (mode_b == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  // stream capture and protocol monitoring, away from the active edge
  bq_t        cap_a, cap_b, exp_q;
  int         perr_a = 0, perr_b = 0;
  logic       pv_a, pr_a, pv_b, pr_b;
  logic [7:0] pc_a, pc_b;

  always @(negedge clk) begin
    if (rst) begin
      pv_a <= 1'b0; pr_a <= 1'b0; pc_a <= 8'h00;
      pv_b <= 1'b0; pr_b <= 1'b0; pc_b <= 8'h00;
    end else begin
      if ((pv_a && !pr_a && (!bus_a.valid || bus_a.data !== pc_a)) ||
          (bus_a.valid && bus_a.vram_ce) || bus_a.vram_w ||
          (!run_a && (bus_a.valid || bus_a.vram_ce)))
        perr_a <= perr_a + 1;
      if ((pv_b && !pr_b && (!bus_b.valid || bus_b.data !== pc_b)) ||
          (bus_b.valid && bus_b.vram_ce) || bus_b.vram_w ||
          (!run_b && (bus_b.valid || bus_b.vram_ce)))
        perr_b <= perr_b + 1;
      if (bus_a.valid && bus_a.ready) cap_a.push_back(bus_a.data);
      if (bus_b.valid && bus_b.ready) cap_b.push_back(bus_b.data);
      pv_a <= bus_a.valid; pr_a <= bus_a.ready; pc_a <= bus_a.data;
      pv_b <= bus_b.valid; pr_b <= bus_b.ready; pc_b <= bus_b.data;
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Reference: what a screen must look like as a stream, straight from the
  // rules (form feed, trimmed/full rows, sanitised chars, CR, LF between rows).
  task automatic build_model(input bit emit_ff, input bit trim);
    int         last;
    logic [7:0] d;
    exp_q.delete();
    if (emit_ff) exp_q.push_back(8'h0C);
    for (int r = 0; r <= LR; r++) begin
      last = LC;
      if (trim) begin
        last = -1;
        for (int c = 0; c <= LC; c++)
          if (mem[{r[4:0], c[5:0]}] != 8'h20) last = c;
      end
      for (int c = 0; c <= last; c++) begin
        d = mem[{r[4:0], c[5:0]}];
        exp_q.push_back((d < 8'h20 || d == 8'h7F) ? 8'h20 : d);
      end
      exp_q.push_back(8'h0D);
      if (r != LR) exp_q.push_back(8'h0A);
    end
  endtask

  task automatic check_stream(input string nm, input int sel);
    bq_t got;
    int  bad;
    got = (sel == 0) ? cap_a : cap_b;
    bad = -1;
    n_tests++;
    if (got.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL %s: got %0d bytes, expected %0d bytes", nm, got.size(), exp_q.size());
    end else begin
      for (int i = 0; i < got.size(); i++)
        if (bad < 0 && got[i] !== exp_q[i]) bad = i;
      if (bad >= 0) begin
        n_fail++;
        $display("FAIL %s: byte %0d got 0x%0h, expected 0x%0h", nm, bad, got[bad], exp_q[bad]);
      end
    end
  endtask

  function automatic logic [7:0] cap_at(input int sel, input int i);
    if (sel == 0) return (i < cap_a.size()) ? cap_a[i] : 8'hxx;
    return (i < cap_b.size()) ? cap_b[i] : 8'hxx;
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < 2048; i++) mem[i] = 8'h20;
  endtask

  task automatic fill_random();
    int len;
    clear_mem();
    for (int r = 0; r <= LR; r++) begin
      len = $urandom_range(0, LC + 1);
      for (int c = 0; c < len; c++)
        mem[{r[4:0], c[5:0]}] = ($urandom_range(0, 4) == 0) ? 8'h20 : 8'($urandom_range(0, 255));
    end
  endtask

  task automatic wait_done(input int sel);
    int cyc = 0;
    while (((sel == 0) ? run_a : run_b) && cyc < 20000) begin
      @(posedge clk); #1;
      cyc++;
    end
    start_a = 1'b0;
    start_b = 1'b0;
    check($sformatf("done_%0d", sel), 32'((sel == 0) ? run_a : run_b), 32'd0);
  endtask

  task automatic wait_valid_a(input string nm);
    int cyc = 0;
    @(negedge clk);
    while (!bus_a.valid && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
    check(nm, 32'(bus_a.valid), 32'd1);
  endtask

  // start a dump and run it to completion; hold_start keeps i_start high
  // for the whole dump (it must be ignored, also at the final handshake)
  task automatic run_dump(input int sel, input bit hold_start);
    if (sel == 0) cap_a.delete(); else cap_b.delete();
    @(posedge clk); #1;
    if (sel == 0) start_a = 1'b1; else start_b = 1'b1;
    @(posedge clk); #1;
    if (!hold_start) begin start_a = 1'b0; start_b = 1'b0; end
    check($sformatf("running_%0d", sel), 32'((sel == 0) ? run_a : run_b), 32'd1);
    if (sel == 0)
      check("first_ff", 32'({bus_a.valid, bus_a.data}), 32'({1'b1, 8'h0C}));
    else
      check("first_rd", 32'({bus_b.vram_ce, bus_b.vram_addr}), 32'({1'b1, 11'd0}));
    wait_done(sel);
  endtask

  typedef struct {
    int         col;
    logic [7:0] din;
    logic [7:0] exp_ch;
    int         exp_len;
  } vec_t;

  vec_t       tbl [9];
  int         stall_err;
  int         n41;
  logic       v1, v2, v3;
  logic [7:0] san_exp [5];

  initial begin
    rst = 1'b1; start_a = 1'b0; start_b = 1'b0;
    mode_a = 0; mode_b = 0; man_rdy_a = 1'b0;
    clear_mem();

    // single char at (0,col), rest blank; exp_ch expected at stream index 1+col
    tbl[0] = '{0,  8'h41, 8'h41, 35};
    tbl[1] = '{0,  8'h07, 8'h20, 35};
    tbl[2] = '{0,  8'h7F, 8'h20, 35};
    tbl[3] = '{0,  8'h20, 8'h0D, 34};
    tbl[4] = '{0,  8'h00, 8'h20, 35};
    tbl[5] = '{0,  8'h1F, 8'h20, 35};
    tbl[6] = '{5,  8'h7E, 8'h7E, 40};
    tbl[7] = '{59, 8'h80, 8'h80, 94};
    tbl[8] = '{30, 8'hFF, 8'hFF, 65};

    repeat (3) @(posedge clk);
    #1;
    check("rst_running_a", 32'(run_a), 32'd0);
    check("rst_valid_a",   32'(bus_a.valid), 32'd0);
    check("rst_char_a",    32'(bus_a.data), 32'd0);
    check("rst_ce_a",      32'(bus_a.vram_ce), 32'd0);
    check("rst_addr_a",    32'(bus_a.vram_addr), 32'd0);
    check("rst_w_a",       32'(bus_a.vram_w), 32'd0);
    check("rst_running_b", 32'(run_b), 32'd0);
    check("rst_ce_b",      32'(bus_b.vram_ce), 32'd0);
    rst = 1'b0;

    // "HI" on row 0
    mem[0] = 8'h48; mem[1] = 8'h49;
    run_dump(0, 1'b0);
    build_model(1'b1, 1'b1);
    check_stream("hi_stream", 0);
    check("hi_len", 32'(cap_a.size()), 32'd36);
    check("hi_b1", 32'(cap_at(0, 1)), 32'h48);
    check("hi_b2", 32'(cap_at(0, 2)), 32'h49);
    check("hi_b3", 32'(cap_at(0, 3)), 32'h0D);
    check("hi_b4", 32'(cap_at(0, 4)), 32'h0A);
    check("hi_last", 32'(cap_at(0, 35)), 32'h0D);

    // single-character table
    for (int i = 0; i < 9; i++) begin
      clear_mem();
      mem[{5'd0, 6'(tbl[i].col)}] = tbl[i].din;
      run_dump(0, 1'b0);
      check($sformatf("tbl%0d_len", i), 32'(cap_a.size()), 32'(tbl[i].exp_len));
      check($sformatf("tbl%0d_ch", i), 32'(cap_at(0, 1 + tbl[i].col)), 32'(tbl[i].exp_ch));
      build_model(1'b1, 1'b1);
      check_stream($sformatf("tbl%0d_stream", i), 0);
    end

    // sanitising
    clear_mem();
    mem[0] = 8'h07; mem[1] = 8'h7F; mem[2] = 8'h58;
    san_exp[0] = 8'h20; san_exp[1] = 8'h20; san_exp[2] = 8'h58;
    san_exp[3] = 8'h0D; san_exp[4] = 8'h0A;
    run_dump(0, 1'b0);
    for (int i = 0; i < 5; i++)
      check($sformatf("san_b%0d", i + 1), 32'(cap_at(0, i + 1)), 32'(san_exp[i]));

    // full row 3
    clear_mem();
    for (int c = 0; c <= LC; c++) mem[{5'd3, 6'(c)}] = 8'h41;
    run_dump(0, 1'b0);
    n41 = 0;
    for (int i = 0; i < cap_a.size(); i++) if (cap_a[i] == 8'h41) n41++;
    check("row3_count", 32'(n41), 32'd60);
    check("row3_cr", 32'(cap_at(0, 67)), 32'h0D);
    build_model(1'b1, 1'b1);
    check_stream("row3_stream_a", 0);
    run_dump(1, 1'b0);
    check("row3_len_b", 32'(cap_b.size()), 32'd1053);
    build_model(1'b0, 1'b0);
    check_stream("row3_stream_b", 1);

    // backpressure
    clear_mem();
    mem[0] = 8'h48; mem[1] = 8'h49;
    mode_a = 2; man_rdy_a = 1'b0; cap_a.delete();
    @(posedge clk); #1 start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
    stall_err = 0;
    repeat (10) begin
      @(negedge clk);
      if (!bus_a.valid || bus_a.data !== 8'h0C || bus_a.vram_ce) stall_err++;
    end
    check("stall_ff", 32'(stall_err), 32'd0);
    @(posedge clk); #1 man_rdy_a = 1'b1;
    @(posedge clk); #1 man_rdy_a = 1'b0;
    wait_valid_a("bp_wait_h");
    check("bp_char_h", 32'(bus_a.data), 32'h48);
    stall_err = 0;
    repeat (10) begin
      @(negedge clk);
      if (!bus_a.valid || bus_a.data !== 8'h48 || bus_a.vram_ce) stall_err++;
    end
    check("stall_h", 32'(stall_err), 32'd0);
    @(posedge clk); #1 man_rdy_a = 1'b1;
    @(posedge clk); #1 man_rdy_a = 1'b0;
    @(negedge clk) v1 = bus_a.valid;
    @(negedge clk) v2 = bus_a.valid;
    @(negedge clk) v3 = bus_a.valid;
    check("bp_gap", 32'({v1, v2, v3}), 32'b001);
    check("bp_char_i", 32'(bus_a.data), 32'h49);
    check("bp_one_xfer", 32'(cap_a.size()), 32'd2);
    mode_a = 0;
    wait_done(0);
    build_model(1'b1, 1'b1);
    check_stream("bp_stream", 0);

    // asynchronous reset mid-SEND, then restart
    mode_a = 2; man_rdy_a = 1'b0;
    @(posedge clk); #1 start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
    @(posedge clk); #1 man_rdy_a = 1'b1;
    @(posedge clk); #1 man_rdy_a = 1'b0;
    wait_valid_a("rst_wait_h");
    #2 rst = 1'b1;
    #1;
    check("arst_valid", 32'(bus_a.valid), 32'd0);
    check("arst_running", 32'(run_a), 32'd0);
    check("arst_ce", 32'(bus_a.vram_ce), 32'd0);
    @(negedge clk); #1 rst = 1'b0;
    mode_a = 0;
    run_dump(0, 1'b0);
    check_stream("restart_stream", 0);

    // i_start held through a randomised dump
    mode_a = 1;
    fill_random();
    run_dump(0, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    check("start_ignored", 32'(run_a), 32'd0);
    build_model(1'b1, 1'b1);
    check_stream("spam_stream", 0);

    // randomised screens, random backpressure
    mode_b = 1;
    for (int k = 0; k < 2; k++) begin
      fill_random();
      run_dump(0, 1'b0);
      build_model(1'b1, 1'b1);
      check_stream($sformatf("rand_a%0d", k), 0);
      run_dump(1, 1'b0);
      build_model(1'b0, 1'b0);
      check_stream($sformatf("rand_b%0d", k), 1);
    end

    @(negedge clk);
    check("protocol_a", 32'(perr_a), 32'd0);
    check("protocol_b", 32'(perr_b), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL global_timeout: simulation did not finish, got running, expected done");
    $fatal(1);
  end
endmodule
